// File: rtl/cv32e40p_fetch_obi_ctrl.sv
// Instruction-fetch OBI request generator with response FIFO feeding the IF aligner.
// Latency: OBI rvalid at cycle T shows up on fetch_valid_o at T+1 (no bypass).
// Backpressure: requests issue only while FIFO count + outstanding < DEPTH, so a stalled consumer stops the bus.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_i                        fetch enable
//   branch_i / branch_addr_i     one-cycle redirect and its target (bits [1:0] ignored)
//   fetch_valid_o/ready_i        valid/ready handshake toward the aligner
//   fetch_rdata_o/err_o          head word and its bus-error flag
//   instr_*                      OBI instruction master
//   busy_o                       request pending or responses still outstanding
module cv32e40p_fetch_obi_ctrl #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        next_addr_q, next_addr_d;
    logic               stale_pend_q, stale_pend_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [OUT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [32:0]        mem_q [DEPTH];
    logic [32:0]        mem_d [DEPTH];

    logic               room;
    logic               gnt;
    logic               stale_gnt;
    logic               drop;
    logic               push;
    logic               pop;
    logic [31:0]        branch_tgt;
    logic               unused_addr_lsb;

    assign branch_tgt      = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_lsb = ^branch_addr_i[1:0];

    // Outstanding transactions reserve FIFO slots, so a push can never find the FIFO full.
    assign room = ((32'(count_q) + 32'(outstanding_q)) < DEPTH) &&
                  (32'(outstanding_q) < MAX_OUTSTANDING);

    // FSM: request generation and OBI address stability
    always_comb begin
        state_d     = state_q;
        instr_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                // rst gate keeps the bus quiet for the whole time reset is held
                instr_req_o = req_i & ~branch_i & room & ~rst;
                if (instr_req_o && !instr_gnt_i) begin
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                // Once raised, the request and its address must stay until granted
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt       = instr_req_o & instr_gnt_i;
    // A request that was pending when a branch arrived is already doomed
    assign stale_gnt = gnt & stale_pend_q;
    assign drop      = instr_rvalid_i & (discard_q != '0);
    assign push      = instr_rvalid_i & (discard_q == '0) & ~branch_i;
    assign pop       = fetch_valid_o & fetch_ready_i & ~branch_i;

    // Address, branch bookkeeping and transaction counters
    always_comb begin
        addr_d        = addr_q;
        next_addr_d   = next_addr_q;
        stale_pend_d  = stale_pend_q;
        outstanding_d = outstanding_q + OUT_W'(gnt) - OUT_W'(instr_rvalid_i);
        discard_d     = discard_q + OUT_W'(stale_gnt) - OUT_W'(drop);

        if (branch_i) begin
            if ((state_q == WAIT_GNT) && !instr_gnt_i) begin
                // Address is frozen by the pending request; park the target
                next_addr_d  = branch_tgt;
                stale_pend_d = 1'b1;
            end else begin
                addr_d       = branch_tgt;
                stale_pend_d = 1'b0;
            end
            // Everything still in flight after this cycle belongs to the old path.
            // A response arriving this cycle is dropped by the flush and excluded here.
            discard_d = outstanding_d;
        end else if (gnt) begin
            addr_d       = stale_pend_q ? next_addr_q : (addr_q + 32'd4);
            stale_pend_d = 1'b0;
        end
    end

    // Response FIFO
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {instr_err_i, instr_rdata_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (branch_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            next_addr_q   <= '0;
            stale_pend_q  <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            next_addr_q   <= next_addr_d;
            stale_pend_q  <= stale_pend_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mem_q         <= mem_d;
        end
    end

    assign instr_addr_o                   = addr_q;
    assign fetch_valid_o                  = (count_q != '0);
    assign {fetch_err_o, fetch_rdata_o}   = mem_q[rd_ptr_q];
    assign busy_o                         = instr_req_o | (outstanding_q != '0);

endmodule

// File: tb/tb_cv32e40p_fetch_obi_ctrl.sv
// Directed bench: behavioural OBI slave (data = addr ^ 0xC0DE0000, 1-cycle response),
// expected fetch words pushed to a queue by the stimulus, popped and compared by a monitor.
module tb_cv32e40p_fetch_obi_ctrl;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_valid_o;
    logic        fetch_ready_i;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    cv32e40p_fetch_obi_ctrl #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [32:0] exp_q [$];
    logic [31:0] slv_q [$];
    logic        resp_en;
    logic [31:0] err_addr;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_i         = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        fetch_ready_i = 1'b0;
        instr_gnt_i   = 1'b0;
        resp_en       = 1'b0;
        err_addr      = 32'hFFFF_FFFF;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Keep req_i high until exactly n grants have been observed
    task automatic fetch_n(input int n);
        int g;
        int guard;
        g     = 0;
        guard = 0;
        req_i = 1'b1;
        while (g < n && guard < 200) begin
            at_neg();
            if (instr_req_o && instr_gnt_i) g++;
            guard++;
            tick();
        end
        req_i = 1'b0;
        chk("fetch_n_grants", 33'(g), 33'(n));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(name, 33'(exp_q.size()), 33'(0));
        repeat (5) tick();
    endtask

    // OBI slave: grant sampled at negedge, response presented in the following cycle
    logic        s_g;
    logic        s_r;
    logic [31:0] s_a;
    initial begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
        forever begin
            at_neg();
            s_g = instr_req_o & instr_gnt_i;
            s_a = instr_addr_o;
            s_r = instr_rvalid_i;
            tick();
            if (rst) begin
                slv_q.delete();
            end else begin
                if (s_r && slv_q.size() > 0) void'(slv_q.pop_front());
                if (s_g) slv_q.push_back(s_a);
            end
            #1;
            if (resp_en && !rst && slv_q.size() > 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = slv_q[0] ^ 32'hC0DE_0000;
                instr_err_i    = (slv_q[0] == err_addr);
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = 32'h0;
                instr_err_i    = 1'b0;
            end
        end
    end

    // Monitor: every accepted fetch word is compared against the expected queue
    logic [32:0] mon_exp;
    initial begin
        forever begin
            at_neg();
            if (!rst && fetch_valid_o && fetch_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, want none", {fetch_err_o, fetch_rdata_o});
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("fetch_word", {fetch_err_o, fetch_rdata_o}, mon_exp);
                end
            end
            if (!rst && instr_rvalid_i && dut.discard_q == 0 && !branch_i &&
                dut.count_q == 4 && !(fetch_valid_o && fetch_ready_i)) begin
                n_fail++;
                $display("FAIL push_when_full: got count %0d, want below 4", dut.count_q);
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        req_i         = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        fetch_ready_i = 1'b0;
        instr_gnt_i   = 1'b0;
        resp_en       = 1'b0;
        err_addr      = 32'hFFFF_FFFF;
        #1 rst = 1'b1;
        #2;
        // Reset values, with req_i high to show the request is held off
        chk("rst_req",   33'(instr_req_o),   33'(0));
        chk("rst_addr",  33'(instr_addr_o),  33'(0));
        chk("rst_valid", 33'(fetch_valid_o), 33'(0));
        chk("rst_rdata", 33'(fetch_rdata_o), 33'(0));
        chk("rst_err",   33'(fetch_err_o),   33'(0));
        chk("rst_busy",  33'(busy_o),        33'(0));
        do_reset();

        // Boot: branch to 0x82 -> fetch 0x80.. on consecutive cycles
        fetch_ready_i = 1'b1;
        instr_gnt_i   = 1'b1;
        resp_en       = 1'b1;
        exp_q.push_back({1'b0, 32'hC0DE_0080});
        exp_q.push_back({1'b0, 32'hC0DE_0084});
        exp_q.push_back({1'b0, 32'hC0DE_0088});
        exp_q.push_back({1'b0, 32'hC0DE_008C});
        exp_q.push_back({1'b0, 32'hC0DE_0090});
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0082;
        req_i         = 1'b1;
        at_neg();
        chk("boot_no_req_branch_cycle", 33'(instr_req_o), 33'(0));
        tick();
        branch_i = 1'b0;
        at_neg();
        chk("boot_req0",  33'(instr_req_o),  33'(1));
        chk("boot_addr0", 33'(instr_addr_o), 33'(32'h80));
        tick();
        at_neg();
        chk("boot_addr1",     33'(instr_addr_o),  33'(32'h84));
        chk("boot_no_bypass", 33'(fetch_valid_o), 33'(0));
        tick();
        fetch_n(3);
        wait_drain("boot_drain");

        // Backpressure: consumer stalled, exactly 4 words buffered
        do_reset();
        instr_gnt_i = 1'b1;
        resp_en     = 1'b1;
        exp_q.push_back({1'b0, 32'hC0DE_0000});
        exp_q.push_back({1'b0, 32'hC0DE_0004});
        exp_q.push_back({1'b0, 32'hC0DE_0008});
        exp_q.push_back({1'b0, 32'hC0DE_000C});
        exp_q.push_back({1'b0, 32'hC0DE_0010});
        req_i = 1'b1;
        repeat (8) tick();
        at_neg();
        chk("bp_req_blocked", 33'(instr_req_o),   33'(0));
        chk("bp_valid",       33'(fetch_valid_o), 33'(1));
        chk("bp_busy_idle",   33'(busy_o),        33'(0));
        tick();
        fetch_ready_i = 1'b1;
        at_neg();
        tick();
        fetch_ready_i = 1'b0;
        at_neg();
        chk("bp_one_req",  33'(instr_req_o),  33'(1));
        chk("bp_one_addr", 33'(instr_addr_o), 33'(32'h10));
        tick();
        at_neg();
        chk("bp_req_blocked_again", 33'(instr_req_o), 33'(0));
        tick();
        req_i         = 1'b0;
        fetch_ready_i = 1'b1;
        wait_drain("bp_drain");

        // Flush: 2 buffered + 2 outstanding (the room reservation caps the sum at 4), branch to 0x1000
        do_reset();
        instr_gnt_i = 1'b1;
        resp_en     = 1'b1;
        fetch_n(2);
        repeat (3) tick();
        resp_en = 1'b0;
        fetch_n(2);
        exp_q.push_back({1'b0, 32'hC0DE_1000});
        exp_q.push_back({1'b0, 32'hC0DE_1004});
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_1000;
        req_i         = 1'b1;
        at_neg();
        chk("flush_pre_valid", 33'(fetch_valid_o), 33'(1));
        chk("flush_no_req",    33'(instr_req_o),   33'(0));
        chk("flush_busy",      33'(busy_o),        33'(1));
        tick();
        branch_i = 1'b0;
        resp_en  = 1'b1;
        at_neg();
        chk("flush_valid_cleared", 33'(fetch_valid_o), 33'(0));
        chk("flush_addr",          33'(instr_addr_o),  33'(32'h1000));
        tick();
        fetch_n(2);
        fetch_ready_i = 1'b1;
        wait_drain("flush_drain");

        // Branch while waiting for a grant at 0x40
        do_reset();
        fetch_ready_i = 1'b1;
        resp_en       = 1'b1;
        exp_q.push_back({1'b0, 32'hC0DE_0200});
        exp_q.push_back({1'b0, 32'hC0DE_0204});
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0040;
        req_i         = 1'b1;
        tick();
        branch_i = 1'b0;
        at_neg();
        chk("wg_req_w0",  33'(instr_req_o),  33'(1));
        chk("wg_addr_w0", 33'(instr_addr_o), 33'(32'h40));
        tick();
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0200;
        req_i         = 1'b0;
        at_neg();
        chk("wg_req_w1",  33'(instr_req_o),  33'(1));
        chk("wg_addr_w1", 33'(instr_addr_o), 33'(32'h40));
        tick();
        branch_i = 1'b0;
        at_neg();
        chk("wg_addr_w2", 33'(instr_addr_o), 33'(32'h40));
        tick();
        instr_gnt_i = 1'b1;
        req_i       = 1'b1;
        at_neg();
        chk("wg_addr_w3", 33'(instr_addr_o), 33'(32'h40));
        tick();
        at_neg();
        chk("wg_req_w4",  33'(instr_req_o),  33'(1));
        chk("wg_addr_w4", 33'(instr_addr_o), 33'(32'h200));
        tick();
        fetch_n(1);
        wait_drain("wg_drain");

        // Bus error on 0x84 only
        do_reset();
        fetch_ready_i = 1'b1;
        instr_gnt_i   = 1'b1;
        resp_en       = 1'b1;
        err_addr      = 32'h0000_0084;
        exp_q.push_back({1'b0, 32'hC0DE_0080});
        exp_q.push_back({1'b1, 32'hC0DE_0084});
        exp_q.push_back({1'b0, 32'hC0DE_0088});
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0080;
        req_i         = 1'b1;
        tick();
        branch_i = 1'b0;
        fetch_n(3);
        wait_drain("err_drain");

        // Asynchronous reset between clock edges in the middle of a burst
        do_reset();
        instr_gnt_i   = 1'b1;
        resp_en       = 1'b1;
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0080;
        req_i         = 1'b1;
        tick();
        branch_i = 1'b0;
        repeat (3) tick();
        at_neg();
        chk("arst_pre_valid", 33'(fetch_valid_o), 33'(1));
        chk("arst_pre_busy",  33'(busy_o),        33'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   33'(instr_req_o),   33'(0));
        chk("arst_addr",  33'(instr_addr_o),  33'(0));
        chk("arst_valid", 33'(fetch_valid_o), 33'(0));
        chk("arst_rdata", 33'(fetch_rdata_o), 33'(0));
        chk("arst_err",   33'(fetch_err_o),   33'(0));
        chk("arst_busy",  33'(busy_o),        33'(0));
        repeat (2) tick();
        req_i = 1'b0;
        do_reset();
        repeat (3) tick();

        chk("leftover_expected", 33'(exp_q.size()), 33'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
